// File: rtl/retire_trace.sv
// Retire trace source: captures one record per retired instruction into a
// show-ahead FIFO and streams it out on a valid/ready interface.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for the first retire; retires are accepted
// S_RUN   | capturing retires into the FIFO
// S_DRAIN | MAX_COUNT retires accepted; new retires ignored, FIFO drains
// S_DONE  | FIFO drained after MAX_COUNT; held until reset
module retire_trace #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned MAX_COUNT = 200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        retire_valid,
    input  logic [31:0] retire_pc,
    input  logic [31:0] retire_instr,
    input  logic [5:0]  retire_type,
    input  logic [4:0]  retire_rd,
    input  logic [4:0]  retire_rs1,
    input  logic [4:0]  retire_rs2,
    input  logic [31:0] retire_rd_val,
    input  logic [31:0] retire_rs1_val,
    input  logic [31:0] retire_rs2_val,
    input  logic        trc_ready,
    output logic        trc_valid,
    output logic [31:0] trc_pc,
    output logic [31:0] trc_instr,
    output logic [5:0]  trc_type,
    output logic [4:0]  trc_rd,
    output logic [4:0]  trc_rs1,
    output logic [4:0]  trc_rs2,
    output logic [31:0] trc_rd_val,
    output logic [31:0] trc_rs1_val,
    output logic [31:0] trc_rs2_val,
    output logic [31:0] trc_seq,
    output logic        trc_bad_type,
    output logic        stall_req,
    output logic        overflow,
    output logic [15:0] drop_count,
    output logic [31:0] retire_count,
    output logic        done
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [5:0]  rtype;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rd_val;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] seq;
        logic        bad_type;
    } rec_t;

    state_t      state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        stall_req_q, stall_req_d;
    logic        overflow_q, overflow_d;
    logic [15:0] drop_count_q, drop_count_d;
    logic [31:0] retire_count_q, retire_count_d;

    rec_t        mem_q [DEPTH];
    rec_t        rec_d;
    rec_t        head;

    logic        empty, full, accepting, push, pop, drop;
    logic [AW:0] occ, occ_next;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign accepting = (state_q == S_IDLE) || (state_q == S_RUN);
    assign pop       = !empty && trc_ready;
    // A same-cycle pop frees the slot, so a full FIFO can still take a push.
    assign push      = accepting && retire_valid && (!full || pop);
    assign drop      = accepting && retire_valid && full && !pop;
    assign occ       = wr_ptr_q - rd_ptr_q;
    assign occ_next  = occ + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        rec_d          = '0;
        rec_d.pc       = retire_pc;
        rec_d.instr    = retire_instr;
        rec_d.rtype    = retire_type;
        rec_d.rd       = retire_rd;
        rec_d.rs1      = retire_rs1;
        rec_d.rs2      = retire_rs2;
        rec_d.rd_val   = (retire_rd == 5'd0) ? 32'd0 : retire_rd_val;
        rec_d.rs1_val  = retire_rs1_val;
        rec_d.rs2_val  = retire_rs2_val;
        rec_d.seq      = retire_count_q;
        rec_d.bad_type = (retire_type == 6'd0) ||
                         ((retire_type & (retire_type - 6'd1)) != 6'd0);
    end

    always_comb begin
        wr_ptr_d       = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d       = rd_ptr_q + (AW+1)'(pop);
        stall_req_d    = (occ_next >= (AW+1)'(DEPTH - 2));
        overflow_d     = overflow_q | drop;
        drop_count_d   = drop_count_q;
        if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
        retire_count_d = retire_count_q + 32'(push);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (push && (retire_count_q == 32'(MAX_COUNT - 1))) begin
                    state_d = S_DRAIN;
                end else if (retire_valid) begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                // Leave on the edge that pops the last record.
                if (occ_next == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            stall_req_q    <= 1'b0;
            overflow_q     <= 1'b0;
            drop_count_q   <= 16'd0;
            retire_count_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            stall_req_q    <= stall_req_d;
            overflow_q     <= overflow_d;
            drop_count_q   <= drop_count_d;
            retire_count_q <= retire_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= rec_d;
        end
    end

    assign head         = mem_q[rd_ptr_q[AW-1:0]];
    assign trc_valid    = !empty;
    assign trc_pc       = head.pc;
    assign trc_instr    = head.instr;
    assign trc_type     = head.rtype;
    assign trc_rd       = head.rd;
    assign trc_rs1      = head.rs1;
    assign trc_rs2      = head.rs2;
    assign trc_rd_val   = head.rd_val;
    assign trc_rs1_val  = head.rs1_val;
    assign trc_rs2_val  = head.rs2_val;
    assign trc_seq      = head.seq;
    assign trc_bad_type = head.bad_type;

    assign stall_req    = stall_req_q;
    assign overflow     = overflow_q;
    assign drop_count   = drop_count_q;
    assign retire_count = retire_count_q;
    assign done         = (state_q == S_DONE);

endmodule
